// File: rtl/cordic_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cordic_ctrl_pkg                                                  |
// | Shared state encoding and default widths for the CORDIC sweeper. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package cordic_ctrl_pkg;

    localparam int N_DEF     = 16;
    localparam int P_DEF     = 18;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cordic_sweep_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cordic_sweep_ctrl                                                |
// | Sweeps the CORDIC angle and hands cos/sin samples downstream.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module cordic_sweep_ctrl
    import cordic_ctrl_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int P     = P_DEF,
    parameter int LAT   = 1,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     theta0,
    input  logic [N-1:0]     step,
    input  logic [CNT_W-1:0] count,
    output logic [N-1:0]     theta_o,
    input  logic [P-1:0]     cos_i,
    input  logic [P-1:0]     sin_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [P-1:0]     cos_o,
    output logic [P-1:0]     sin_o,
    output logic [CNT_W-1:0] idx_o,
    output logic             busy,
    output logic             done
);

    localparam int           WW       = $clog2(LAT + 1);
    localparam logic [WW-1:0] c_reload = WW'(LAT - 1);

    state_t           r_state;
    logic [N-1:0]     r_step;
    logic [CNT_W-1:0] r_count;
    logic [WW-1:0]    r_wait;
    logic [N-1:0]     r_theta;
    logic [P-1:0]     r_cos;
    logic [P-1:0]     r_sin;
    logic [CNT_W-1:0] r_idx;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_last;

    assign w_last = (r_idx == r_count - CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_step  <= '0;
            r_count <= '0;
            r_wait  <= '0;
            r_theta <= '0;
            r_cos   <= '0;
            r_sin   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            r_step  <= step;
                            r_count <= count;
                            r_theta <= theta0;
                            r_idx   <= '0;
                            r_wait  <= c_reload;
                            r_busy  <= 1'b1;
                            r_state <= ST_WAIT;
                        end else begin
                            // Empty sweep: report completion without producing data.
                            r_done  <= 1'b1;
                            r_state <= ST_FIN;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_wait == '0) begin
                        r_cos   <= cos_i;
                        r_sin   <= sin_i;
                        r_valid <= 1'b1;
                        r_state <= ST_HOLD;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_FIN;
                        end else begin
                            // Angle wraps modulo 2^N by construction.
                            r_theta <= r_theta + r_step;
                            r_idx   <= r_idx + 1'b1;
                            r_wait  <= c_reload;
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign theta_o   = r_theta;
    assign cos_o     = r_cos;
    assign sin_o     = r_sin;
    assign idx_o     = r_idx;
    assign out_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cordic_sweep_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_cordic_sweep_ctrl                                             |
// | Directed bench for the sweeper at LAT=1 and LAT=3.               |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_cordic_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] theta0;
    logic [15:0] step;
    logic [7:0]  count;
    logic        start1, ready1, start3, ready3;

    logic [15:0] theta1, theta3;
    logic [17:0] cosi1, sini1, cosi3, sini3;
    logic [17:0] cos1, sin1, cos3, sin3;
    logic [7:0]  idx1, idx3;
    logic        valid1, busy1, done1, valid3, busy3, done3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Stand-in for the CORDIC: an easily predicted function of the angle.
    function automatic logic [17:0] cos_of(input logic [15:0] t);
        return {t, 2'b10};
    endfunction
    function automatic logic [17:0] sin_of(input logic [15:0] t);
        return {~t, 2'b01};
    endfunction

    assign cosi1 = cos_of(theta1);
    assign sini1 = sin_of(theta1);
    assign cosi3 = cos_of(theta3);
    assign sini3 = sin_of(theta3);

    cordic_sweep_ctrl #(.N(16), .P(18), .LAT(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .theta0(theta0), .step(step),
        .count(count), .theta_o(theta1), .cos_i(cosi1), .sin_i(sini1),
        .out_valid(valid1), .out_ready(ready1), .cos_o(cos1), .sin_o(sin1),
        .idx_o(idx1), .busy(busy1), .done(done1)
    );

    cordic_sweep_ctrl #(.N(16), .P(18), .LAT(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .theta0(theta0), .step(step),
        .count(count), .theta_o(theta3), .cos_i(cosi3), .sin_i(sini3),
        .out_valid(valid3), .out_ready(ready3), .cos_o(cos3), .sin_o(sin3),
        .idx_o(idx3), .busy(busy3), .done(done3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start1 = 0; start3 = 0; ready1 = 0; ready3 = 0;
        theta0 = 0; step = 0; count = 0;
        tick(); tick();
        checks++;
        if ({theta1, cos1, sin1, idx1, valid1, busy1, done1} !== '0) begin
            errors++; $display("FAIL reset_dut1 got th=%0d v=%0b b=%0b d=%0b exp all 0", theta1, valid1, busy1, done1);
        end
        checks++;
        if ({theta3, cos3, sin3, idx3, valid3, busy3, done3} !== '0) begin
            errors++; $display("FAIL reset_dut3 got th=%0d v=%0b b=%0b d=%0b exp all 0", theta3, valid3, busy3, done3);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sweep16();
        logic [15:0] exp_th;
        theta0 = 16'd0; step = 16'd3276; count = 8'd16; ready1 = 1; start1 = 1;
        tick();
        start1 = 0;
        checks++;
        if (busy1 !== 1'b1 || valid1 !== 1'b0 || theta1 !== 16'd0) begin
            errors++; $display("FAIL sweep_start got b=%0b v=%0b th=%0d exp b=1 v=0 th=0", busy1, valid1, theta1);
        end
        exp_th = 16'd0;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (valid1 !== 1'b1 || idx1 !== 8'(i) || theta1 !== exp_th ||
                cos1 !== cos_of(exp_th) || sin1 !== sin_of(exp_th)) begin
                errors++; $display("FAIL sweep_sample%0d got v=%0b idx=%0d th=%0d cos=%h exp v=1 idx=%0d th=%0d cos=%h",
                                   i, valid1, idx1, $signed(theta1), cos1, i, $signed(exp_th), cos_of(exp_th));
            end
            if (i == 10) begin
                checks++;
                if (theta1 !== 16'd32760) begin
                    errors++; $display("FAIL sweep_peak got %0d exp 32760", $signed(theta1));
                end
            end
            if (i == 11) begin
                checks++;
                if ($signed(theta1) !== -16'sd29500) begin
                    errors++; $display("FAIL sweep_wrap got %0d exp -29500", $signed(theta1));
                end
            end
            if (i == 15) begin
                checks++;
                if ($signed(theta1) !== -16'sd16396) begin
                    errors++; $display("FAIL sweep_last_theta got %0d exp -16396", $signed(theta1));
                end
            end
            tick();
            exp_th = exp_th + 16'd3276;
            checks++;
            if (i < 15) begin
                if (valid1 !== 1'b0 || busy1 !== 1'b1 || done1 !== 1'b0 || theta1 !== exp_th) begin
                    errors++; $display("FAIL sweep_advance%0d got v=%0b b=%0b d=%0b th=%0d exp v=0 b=1 d=0 th=%0d",
                                       i, valid1, busy1, done1, $signed(theta1), $signed(exp_th));
                end
            end else begin
                if (done1 !== 1'b1 || busy1 !== 1'b0 || valid1 !== 1'b0) begin
                    errors++; $display("FAIL sweep_done got d=%0b b=%0b v=%0b exp d=1 b=0 v=0", done1, busy1, valid1);
                end
            end
        end
        tick();
        checks++;
        if (done1 !== 1'b0 || $signed(theta1) !== -16'sd16396 || idx1 !== 8'd15) begin
            errors++; $display("FAIL sweep_after got d=%0b th=%0d idx=%0d exp d=0 th=-16396 idx=15", done1, $signed(theta1), idx1);
        end
    endtask

    task automatic test_backpressure();
        theta0 = 16'd0; step = 16'd3276; count = 8'd5; ready1 = 1; start1 = 1;
        tick();
        start1 = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); tick();
        end
        tick();
        ready1 = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (valid1 !== 1'b1 || idx1 !== 8'd3 || theta1 !== 16'd9828 ||
                cos1 !== cos_of(16'd9828) || sin1 !== sin_of(16'd9828)) begin
                errors++; $display("FAIL bp_hold%0d got v=%0b idx=%0d th=%0d cos=%h exp v=1 idx=3 th=9828 cos=%h",
                                   c, valid1, idx1, theta1, cos1, cos_of(16'd9828));
            end
        end
        ready1 = 1;
        tick();
        checks++;
        if (valid1 !== 1'b0 || idx1 !== 8'd4 || theta1 !== 16'd13104) begin
            errors++; $display("FAIL bp_release got v=%0b idx=%0d th=%0d exp v=0 idx=4 th=13104", valid1, idx1, theta1);
        end
        tick(); tick();
        checks++;
        if (done1 !== 1'b1) begin
            errors++; $display("FAIL bp_done got %0b exp 1", done1);
        end
        tick();
    endtask

    task automatic test_count0();
        count = 8'd0; theta0 = 16'd777; start1 = 1;
        tick();
        start1 = 0;
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || valid1 !== 1'b0) begin
            errors++; $display("FAIL count0_pulse got d=%0b b=%0b v=%0b exp d=1 b=0 v=0", done1, busy1, valid1);
        end
        tick();
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b0 || valid1 !== 1'b0) begin
            errors++; $display("FAIL count0_end got d=%0b b=%0b v=%0b exp d=0 b=0 v=0", done1, busy1, valid1);
        end
    endtask

    task automatic test_lat3();
        theta0 = 16'hE000; step = 16'd100; count = 8'd1; ready3 = 1; start3 = 1;
        tick();
        start3 = 0;
        checks++;
        if (busy3 !== 1'b1 || valid3 !== 1'b0 || $signed(theta3) !== -16'sd8192) begin
            errors++; $display("FAIL lat3_start got b=%0b v=%0b th=%0d exp b=1 v=0 th=-8192", busy3, valid3, $signed(theta3));
        end
        for (int e = 1; e < 3; e++) begin
            tick();
            checks++;
            if (valid3 !== 1'b0) begin
                errors++; $display("FAIL lat3_early%0d got v=%0b exp 0", e, valid3);
            end
        end
        tick();
        checks++;
        if (valid3 !== 1'b1 || $signed(theta3) !== -16'sd8192 || idx3 !== 8'd0 || cos3 !== cos_of(16'hE000)) begin
            errors++; $display("FAIL lat3_capture got v=%0b th=%0d idx=%0d cos=%h exp v=1 th=-8192 idx=0 cos=%h",
                               valid3, $signed(theta3), idx3, cos3, cos_of(16'hE000));
        end
        tick();
        checks++;
        if (done3 !== 1'b1 || busy3 !== 1'b0 || valid3 !== 1'b0) begin
            errors++; $display("FAIL lat3_done got d=%0b b=%0b v=%0b exp d=1 b=0 v=0", done3, busy3, valid3);
        end
        tick();
        checks++;
        if (done3 !== 1'b0 || $signed(theta3) !== -16'sd8192) begin
            errors++; $display("FAIL lat3_after got d=%0b th=%0d exp d=0 th=-8192", done3, $signed(theta3));
        end
    endtask

    task automatic test_back_to_back();
        theta0 = 16'd1000; step = 16'd10; count = 8'd3; ready1 = 1; start1 = 1;
        tick();
        theta0 = 16'd5000; step = 16'd77; count = 8'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (valid1 !== 1'b1 || idx1 !== 8'(i) || theta1 !== 16'(1000 + 10 * i)) begin
                errors++; $display("FAIL b2b_sample%0d got v=%0b idx=%0d th=%0d exp v=1 idx=%0d th=%0d",
                                   i, valid1, idx1, theta1, i, 1000 + 10 * i);
            end
            if (i == 2) start1 = 0;
            tick();
        end
        checks++;
        if (done1 !== 1'b1) begin
            errors++; $display("FAIL b2b_done got %0b exp 1", done1);
        end
        tick();
        count = 8'd2; start1 = 1;
        tick();
        start1 = 0;
        checks++;
        if (busy1 !== 1'b1 || theta1 !== 16'd5000) begin
            errors++; $display("FAIL b2b_restart got b=%0b th=%0d exp b=1 th=5000", busy1, theta1);
        end
        tick(); tick(); tick();
        checks++;
        if (valid1 !== 1'b1 || theta1 !== 16'd5077 || idx1 !== 8'd1) begin
            errors++; $display("FAIL b2b_second got v=%0b th=%0d idx=%0d exp v=1 th=5077 idx=1", valid1, theta1, idx1);
        end
        tick();
        checks++;
        if (done1 !== 1'b1) begin
            errors++; $display("FAIL b2b_done2 got %0b exp 1", done1);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        theta0 = 16'd0; step = 16'd3276; count = 8'd8; ready1 = 1; start1 = 1;
        tick();
        start1 = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); tick();
        end
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({theta1, cos1, sin1, idx1, valid1, busy1, done1} !== '0) begin
            errors++; $display("FAIL midrst_async got th=%0d idx=%0d v=%0b b=%0b d=%0b exp all 0", theta1, idx1, valid1, busy1, done1);
        end
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b0 || valid1 !== 1'b0 || theta1 !== 16'd0) begin
            errors++; $display("FAIL midrst_idle got d=%0b b=%0b v=%0b th=%0d exp all 0", done1, busy1, valid1, theta1);
        end
        theta0 = 16'd500; step = 16'd1; count = 8'd1; start1 = 1;
        tick();
        start1 = 0;
        tick();
        checks++;
        if (valid1 !== 1'b1 || theta1 !== 16'd500 || cos1 !== cos_of(16'd500) || sin1 !== sin_of(16'd500)) begin
            errors++; $display("FAIL midrst_fresh got v=%0b th=%0d cos=%h exp v=1 th=500 cos=%h", valid1, theta1, cos1, cos_of(16'd500));
        end
        tick();
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++; $display("FAIL midrst_done got d=%0b b=%0b exp d=1 b=0", done1, busy1);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_sweep16();
        test_backpressure();
        test_count0();
        test_lat3();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
